// File: rtl/pet_pkg.sv
// Shared constants for the pet needs datapath: action codes, need range, FSM states
// and the restore-amount clipping helper used by pet_action_ctrl.
package pet_pkg;

  localparam int NEED_W = 3;
  localparam logic [NEED_W-1:0] NEED_MAX = 3'd7;

  typedef enum logic [1:0] {
    ACT_FEED  = 2'd0,
    ACT_SLEEP = 2'd1,
    ACT_PLAY  = 2'd2
  } act_code_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } act_state_e;

  // Largest increment that keeps the need at or below NEED_MAX; 0 means "already full".
  function automatic logic [NEED_W-1:0] clip_amount(input logic [NEED_W-1:0] value,
                                                    input logic [NEED_W-1:0] step);
    logic [NEED_W-1:0] room;
    room = NEED_MAX - value;
    return (step < room) ? step : room;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input path: 2-flop synchroniser, saturating debounce counter and a
// single-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       sync2_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       level_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign level_o = (cnt_q == CNT_MAX);
  // A held button keeps level_o high, so only the first cycle produces a press.
  assign press_o = level_o & ~level_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_o;
    end
  end

endmodule

// File: rtl/pet_action_ctrl.sv
// Turns debounced feed/sleep/play presses into clipped restore commands with a cooldown.
// Define PET_ACTION_COUNT_EN to add saturating per-code handshake counters.
module pet_action_ctrl
  import pet_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned STEP            = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_feed,
  input  logic              btn_sleep,
  input  logic              btn_play,
  input  logic [NEED_W-1:0] foodValue,
  input  logic [NEED_W-1:0] sleepValue,
  input  logic [NEED_W-1:0] funValue,
  output logic              act_valid,
  output logic [1:0]        act_code,
  output logic [NEED_W-1:0] act_amount,
  input  logic              act_ready,
  output logic              act_reject,
  output logic              busy,
`ifdef PET_ACTION_COUNT_EN
  output logic [7:0]        cnt_feed,
  output logic [7:0]        cnt_sleep,
  output logic [7:0]        cnt_play,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam logic [NEED_W-1:0] STEP_V = NEED_W'(STEP);
  localparam logic [15:0]       COOL_V = 16'(COOLDOWN_CYCLES);

  // Handshake: act_valid holds code/amount stable until an edge samples act_ready=1;
  // that edge completes the transfer. act_ready has no effect while act_valid is low.

  logic [2:0]        press;
  logic [2:0]        level_unused;

  act_state_e        state_q, state_d;
  logic [2:0]        pending_q, pending_d;
  logic [2:0]        pend_clr;
  act_code_e         code_q, code_d;
  logic [NEED_W-1:0] amount_q, amount_d;
  logic              reject_q, reject_d;
  logic [15:0]       cool_q, cool_d;
  logic              handshake;

  act_code_e         sel_code;
  logic [NEED_W-1:0] sel_value;
  logic [2:0]        sel_mask;
  logic [NEED_W-1:0] sel_amount;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_feed (
    .clk(clk), .rst(rst), .btn_i(btn_feed),  .level_o(level_unused[0]), .press_o(press[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sleep (
    .clk(clk), .rst(rst), .btn_i(btn_sleep), .level_o(level_unused[1]), .press_o(press[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clk(clk), .rst(rst), .btn_i(btn_play),  .level_o(level_unused[2]), .press_o(press[2])
  );

  // Fixed priority feed > sleep > play.
  always_comb begin
    sel_code  = ACT_PLAY;
    sel_value = funValue;
    sel_mask  = 3'b100;
    if (pending_q[0]) begin
      sel_code  = ACT_FEED;
      sel_value = foodValue;
      sel_mask  = 3'b001;
    end else if (pending_q[1]) begin
      sel_code  = ACT_SLEEP;
      sel_value = sleepValue;
      sel_mask  = 3'b010;
    end
  end

  assign sel_amount = clip_amount(sel_value, STEP_V);

  always_comb begin
    state_d   = state_q;
    pend_clr  = '0;
    code_d    = code_q;
    amount_d  = amount_q;
    reject_d  = 1'b0;
    cool_d    = cool_q;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          if (sel_amount == '0) begin
            pend_clr = sel_mask;
            reject_d = 1'b1;
          end else begin
            code_d   = sel_code;
            amount_d = sel_amount;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (act_ready) begin
          handshake = 1'b1;
          pend_clr  = 3'b001 << code_q;
          cool_d    = COOL_V;
          code_d    = ACT_FEED;
          amount_d  = '0;
          state_d   = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cool_q != '0) begin
          cool_d = cool_q - 16'd1;
        end
        if (cool_q <= 16'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A press landing on the same edge as its clear wins, so the request is kept.
  assign pending_d = (pending_q & ~pend_clr) | press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      code_q    <= ACT_FEED;
      amount_q  <= '0;
      reject_q  <= 1'b0;
      cool_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      amount_q  <= amount_d;
      reject_q  <= reject_d;
      cool_q    <= cool_d;
    end
  end

  assign act_valid   = (state_q == ST_ISSUE);
  assign act_code    = code_q;
  assign act_amount  = amount_q;
  assign act_reject  = reject_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

`ifdef PET_ACTION_COUNT_EN
  logic [7:0] cnt_feed_q, cnt_feed_d;
  logic [7:0] cnt_sleep_q, cnt_sleep_d;
  logic [7:0] cnt_play_q, cnt_play_d;

  always_comb begin
    cnt_feed_d  = cnt_feed_q;
    cnt_sleep_d = cnt_sleep_q;
    cnt_play_d  = cnt_play_q;
    if (handshake) begin
      case (code_q)
        ACT_FEED:  if (cnt_feed_q  != 8'hFF) cnt_feed_d  = cnt_feed_q  + 8'd1;
        ACT_SLEEP: if (cnt_sleep_q != 8'hFF) cnt_sleep_d = cnt_sleep_q + 8'd1;
        ACT_PLAY:  if (cnt_play_q  != 8'hFF) cnt_play_d  = cnt_play_q  + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_feed_q  <= '0;
      cnt_sleep_q <= '0;
      cnt_play_q  <= '0;
    end else begin
      cnt_feed_q  <= cnt_feed_d;
      cnt_sleep_q <= cnt_sleep_d;
      cnt_play_q  <= cnt_play_d;
    end
  end

  assign cnt_feed  = cnt_feed_q;
  assign cnt_sleep = cnt_sleep_q;
  assign cnt_play  = cnt_play_q;
`endif

endmodule

// File: tb/tb_pet_action_ctrl.sv
// Directed bench for pet_action_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=16, STEP=2.
module tb_pet_action_ctrl;
  import pet_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_feed = 1'b0, btn_sleep = 1'b0, btn_play = 1'b0;
  logic [2:0] foodValue = '0, sleepValue = '0, funValue = '0;
  logic       act_valid;
  logic [1:0] act_code;
  logic [2:0] act_amount;
  logic       act_ready = 1'b0;
  logic       act_reject;
  logic       busy;
  logic [1:0] dbg_state;
`ifdef PET_ACTION_COUNT_EN
  logic [7:0] cnt_feed, cnt_sleep, cnt_play;
`endif

  pet_action_ctrl #(.DEBOUNCE_CYCLES(4), .COOLDOWN_CYCLES(16), .STEP(2)) dut (
    .clk(clk), .rst(rst),
    .btn_feed(btn_feed), .btn_sleep(btn_sleep), .btn_play(btn_play),
    .foodValue(foodValue), .sleepValue(sleepValue), .funValue(funValue),
    .act_valid(act_valid), .act_code(act_code), .act_amount(act_amount),
    .act_ready(act_ready), .act_reject(act_reject), .busy(busy),
`ifdef PET_ACTION_COUNT_EN
    .cnt_feed(cnt_feed), .cnt_sleep(cnt_sleep), .cnt_play(cnt_play),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: everything sampled mid-cycle
  logic [4:0] hs_q[$];
  int         hs_cyc_q[$];
  int         valid_seen = 0;
  int         reject_seen = 0;
  always @(negedge clk) begin
    if (act_valid) valid_seen++;
    if (act_reject) reject_seen++;
    if (act_valid && act_ready) begin
      hs_q.push_back({act_code, act_amount});
      hs_cyc_q.push_back(cyc);
    end
  end

  // scoreboard
  logic [4:0] exp_q[$];
  int         hs_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drain_hs(input string tag);
    logic [4:0] e;
    check({tag, "_count"}, hs_q.size() - hs_rd, exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (hs_rd < hs_q.size()) begin
        check(tag, {27'd0, hs_q[hs_rd]}, {27'd0, e});
        hs_rd++;
      end
    end
    hs_rd = hs_q.size();
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n;
    n = 0;
    while (!act_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, act_valid, 1);
  endtask

  task automatic set_btns(input logic [2:0] b);
    btn_feed  = b[0];
    btn_sleep = b[1];
    btn_play  = b[2];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, r0, bcnt, unstable, base;

    // reset state
    #12;
    check("rst_valid", act_valid, 0);
    check("rst_code", act_code, 0);
    check("rst_amount", act_amount, 0);
    check("rst_reject", act_reject, 0);
    check("rst_busy", busy, 0);
    ticks(2);
    rst = 1'b1;
    ticks(2);

    // T1: held feed press, latency, cooldown length, single action
    foodValue = 3'd3;
    act_ready = 1'b1;
    v0 = valid_seen;
    set_btns(3'b001);
    ticks(7);
    check("t1_valid_early", act_valid, 0);
    tick();
    check("t1_valid", act_valid, 1);
    check("t1_code", act_code, 0);
    check("t1_amount", act_amount, 2);
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) bcnt++;
      tick();
    end
    check("t1_busy_cycles", bcnt, 17);
    check("t1_valid_cycles", valid_seen - v0, 1);
    exp_q.push_back({2'd0, 3'd2});
    drain_hs("t1_hs");
    set_btns(3'b000);
    ticks(8);

    // T2: 3-cycle glitch is filtered
    v0 = valid_seen;
    set_btns(3'b001);
    ticks(3);
    set_btns(3'b000);
    ticks(15);
    check("t2_valid_cycles", valid_seen - v0, 0);
    check("t2_busy", busy, 0);
    drain_hs("t2_hs");

    // T3: all three at once, priority order and spacing
    foodValue = 3'd0; sleepValue = 3'd0; funValue = 3'd0;
    base = hs_rd;
    set_btns(3'b111);
    ticks(10);
    set_btns(3'b000);
    ticks(60);
    exp_q.push_back({2'd0, 3'd2});
    exp_q.push_back({2'd1, 3'd2});
    exp_q.push_back({2'd2, 3'd2});
    if (hs_cyc_q.size() >= base + 3) begin
      check("t3_gap01", hs_cyc_q[base+1] - hs_cyc_q[base], 18);
      check("t3_gap12", hs_cyc_q[base+2] - hs_cyc_q[base+1], 18);
    end
    drain_hs("t3_hs");

    // T4: clipping to 1, then reject when full
    sleepValue = 3'd6;
    set_btns(3'b010);
    ticks(10);
    set_btns(3'b000);
    ticks(30);
    exp_q.push_back({2'd1, 3'd1});
    drain_hs("t4_clip_hs");
    sleepValue = 3'd7;
    v0 = valid_seen;
    r0 = reject_seen;
    set_btns(3'b010);
    ticks(10);
    set_btns(3'b000);
    ticks(10);
    check("t4_reject_pulses", reject_seen - r0, 1);
    check("t4_no_valid", valid_seen - v0, 0);
    drain_hs("t4_reject_hs");

    // T5: back-pressure, outputs frozen while need value moves
    act_ready = 1'b0;
    foodValue = 3'd5;
    set_btns(3'b001);
    wait_valid(20, "t5_wait_valid");
    set_btns(3'b000);
    unstable = 0;
    for (int i = 0; i < 20; i++) begin
      foodValue = 3'(i);
      tick();
      if (!(act_valid === 1'b1 && act_code === 2'd0 && act_amount === 3'd2)) unstable++;
    end
    check("t5_unstable_cycles", unstable, 0);
    act_ready = 1'b1;
    tick();
    check("t5_valid_after_hs", act_valid, 0);
    check("t5_busy_after_hs", busy, 1);
    exp_q.push_back({2'd0, 3'd2});
    drain_hs("t5_hs");
    ticks(20);

    // T6: asynchronous reset mid-issue drops valid and pending requests
    act_ready = 1'b0;
    foodValue = 3'd0;
    sleepValue = 3'd0;
    set_btns(3'b011);
    wait_valid(20, "t6_wait_valid");
    set_btns(3'b000);
    ticks(2);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_valid", act_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_code", act_code, 0);
    check("t6_rst_amount", act_amount, 0);
    ticks(3);
    rst = 1'b1;
    act_ready = 1'b1;
    v0 = valid_seen;
    ticks(40);
    check("t6_no_valid_after_rst", valid_seen - v0, 0);
    drain_hs("t6_post_rst_hs");
    set_btns(3'b001);
    ticks(10);
    set_btns(3'b000);
    ticks(30);
    exp_q.push_back({2'd0, 3'd2});
    drain_hs("t6_new_press_hs");

`ifdef PET_ACTION_COUNT_EN
    check("cnt_feed", cnt_feed, 1);
    check("cnt_sleep", cnt_sleep, 0);
    check("cnt_play", cnt_play, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
